// File: rtl/sprite_pkg.sv
// Shared constants for the sprite collision tracker: screen extent, shape codes,
// car outline offsets and the frame FSM state encoding.
package sprite_pkg;

  localparam int SCREEN_W   = 96;
  localparam int SCREEN_H   = 64;

  localparam int SHAPE_RECT = 0;
  localparam int SHAPE_CAR  = 1;

  localparam logic [7:0] RECT_DX_MAX = 8'd9;
  localparam logic [7:0] RECT_DY_MAX = 8'd7;

  // Wheel columns {1,2,5,6} and rows {0,1,6,7} as bit masks indexed by offset.
  localparam logic [15:0] CAR_WHEEL_DX = 16'h0066;
  localparam logic [7:0]  CAR_WHEEL_DY = 8'hC3;

  localparam logic [7:0] CAR_CHASSIS_DX_MAX = 8'd8;
  localparam logic [7:0] CAR_CHASSIS_DY_MIN = 8'd2;
  localparam logic [7:0] CAR_CHASSIS_DY_MAX = 8'd5;
  localparam logic [7:0] CAR_NOSE_DX        = 8'd9;
  localparam logic [7:0] CAR_NOSE_DY_MIN    = 8'd3;
  localparam logic [7:0] CAR_NOSE_DY_MAX    = 8'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PUBLISH
  } state_e;

endpackage

// File: rtl/sprite_shape_test.sv
// Combinational hit test of one pixel against one sprite outline at a given origin.
module sprite_shape_test
  import sprite_pkg::*;
#(
  parameter int SHAPE_MODE = SHAPE_CAR
) (
  input  logic [6:0] pixel_x_i,
  input  logic [5:0] pixel_y_i,
  input  logic [6:0] org_x_i,
  input  logic [5:0] org_y_i,
  input  logic       en_i,
  output logic       hit_o
);

  logic [7:0] dx;
  logic [7:0] dy;
  logic       in_front;
  logic       shape_hit;

  assign dx = {1'b0, pixel_x_i} - {1'b0, org_x_i};
  assign dy = {2'b0, pixel_y_i} - {2'b0, org_y_i};
  // Pixels left of or above the origin never hit, so the 8-bit difference cannot wrap into range.
  assign in_front = (pixel_x_i >= org_x_i) && (pixel_y_i >= org_y_i);

  always_comb begin
    shape_hit = 1'b0;
    if (SHAPE_MODE == SHAPE_RECT) begin
      shape_hit = (dx <= RECT_DX_MAX) && (dy <= RECT_DY_MAX);
    end else if ((dx <= RECT_DX_MAX) && (dy <= RECT_DY_MAX)) begin
      shape_hit = (CAR_WHEEL_DX[dx[3:0]] && CAR_WHEEL_DY[dy[2:0]])
               || ((dx <= CAR_CHASSIS_DX_MAX)
                   && (dy >= CAR_CHASSIS_DY_MIN) && (dy <= CAR_CHASSIS_DY_MAX))
               || ((dx == CAR_NOSE_DX)
                   && (dy >= CAR_NOSE_DY_MIN) && (dy <= CAR_NOSE_DY_MAX));
    end
  end

  assign hit_o = en_i && in_front && shape_hit;

endmodule

// File: rtl/sprite_collision_tracker.sv
// Per-pixel sprite hit detection with a per-frame collision mask published over valid/ready.
// Last pixel to coll_valid is 3 cycles; an unaccepted result is overwritten and flagged sticky.
module sprite_collision_tracker #(
  parameter int N_SPRITES  = 4,
  parameter int SHAPE_MODE = 1,
  parameter int SCREEN_W   = sprite_pkg::SCREEN_W,
  parameter int SCREEN_H   = sprite_pkg::SCREEN_H
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   pixel_valid,
  input  logic [6:0]             pixel_x,
  input  logic [5:0]             pixel_y,
  input  logic [7*N_SPRITES-1:0] sprite_x,
  input  logic [6*N_SPRITES-1:0] sprite_y,
  input  logic [N_SPRITES-1:0]   sprite_en,
  output logic [N_SPRITES-1:0]   pix_hit,
  output logic [N_SPRITES-1:0]   coll_mask,
  output logic                   coll_valid,
  input  logic                   coll_ready,
  output logic                   coll_overrun
);

  import sprite_pkg::*;

  state_e                 state_q;
  logic [7*N_SPRITES-1:0] shx_q;
  logic [6*N_SPRITES-1:0] shy_q;
  logic [N_SPRITES-1:0]   shen_q;
  logic [N_SPRITES-1:0]   hit_d;
  logic [N_SPRITES-1:0]   pix_hit_q;
  logic [N_SPRITES-1:0]   acc_q;
  logic [N_SPRITES-1:0]   coll_mask_q;
  logic                   coll_valid_q;
  logic                   coll_overrun_q;
  logic                   hit_new_q;
  logic                   last_q;
  logic                   scan_pix_d;
  logic                   is_last_pix;
  logic                   multi_hit;

  for (genvar i = 0; i < N_SPRITES; i++) begin : g_shape
    sprite_shape_test #(
      .SHAPE_MODE(SHAPE_MODE)
    ) u_shape (
      .pixel_x_i(pixel_x),
      .pixel_y_i(pixel_y),
      .org_x_i  (shx_q[7*i +: 7]),
      .org_y_i  (shy_q[6*i +: 6]),
      .en_i     (shen_q[i]),
      .hit_o    (hit_d[i])
    );
  end

  // A pixel sharing its cycle with frame_start belongs to no frame.
  assign scan_pix_d  = pixel_valid && (state_q == ST_SCAN) && !frame_start;
  assign is_last_pix = (pixel_x == 7'(SCREEN_W - 1)) && (pixel_y == 6'(SCREEN_H - 1));
  assign multi_hit   = (pix_hit_q & (pix_hit_q - N_SPRITES'(1))) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shx_q     <= '0;
      shy_q     <= '0;
      shen_q    <= '0;
      pix_hit_q <= '0;
      hit_new_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      if (frame_start) begin
        shx_q  <= sprite_x;
        shy_q  <= sprite_y;
        shen_q <= sprite_en;
      end
      if (pixel_valid) begin
        pix_hit_q <= hit_d;
      end
      hit_new_q <= scan_pix_d;
      last_q    <= scan_pix_d && is_last_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      coll_mask_q    <= '0;
      coll_valid_q   <= 1'b0;
      coll_overrun_q <= 1'b0;
    end else begin
      if (coll_valid_q && coll_ready) begin
        coll_valid_q <= 1'b0;
      end
      if (frame_start) begin
        state_q <= ST_SCAN;
        acc_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_SCAN: begin
            if (hit_new_q && multi_hit) begin
              acc_q <= acc_q | pix_hit_q;
            end
            if (last_q) begin
              state_q <= ST_PUBLISH;
            end
          end
          ST_PUBLISH: state_q <= ST_IDLE;
          default:    state_q <= ST_IDLE;
        endcase
      end
      // A completed frame publishes even if a new frame_start arrives in the same cycle.
      if (state_q == ST_PUBLISH) begin
        coll_mask_q  <= acc_q;
        coll_valid_q <= 1'b1;
        if (coll_valid_q && !coll_ready) begin
          coll_overrun_q <= 1'b1;
        end
      end
    end
  end

  assign pix_hit      = pix_hit_q;
  assign coll_mask    = coll_mask_q;
  assign coll_valid   = coll_valid_q;
  assign coll_overrun = coll_overrun_q;

endmodule

// File: tb/tb_sprite_collision_tracker.sv
// Directed bench for sprite_collision_tracker: expected masks are queued at stimulus time
// and popped by a monitor on each accepted result.
module tb_sprite_collision_tracker;

  localparam int N = 4;
  localparam int W = 96;
  localparam int H = 64;
  localparam int LAST_IDX = W * H - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_start;
  logic         pixel_valid;
  logic [6:0]   pixel_x;
  logic [5:0]   pixel_y;
  logic [7*N-1:0] sprite_x;
  logic [6*N-1:0] sprite_y;
  logic [N-1:0] sprite_en;
  logic [N-1:0] pix_hit;
  logic [N-1:0] coll_mask;
  logic         coll_valid;
  logic         coll_ready;
  logic         coll_overrun;

  int total = 0;
  int bad   = 0;
  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  sprite_collision_tracker #(
    .N_SPRITES (N),
    .SHAPE_MODE(1),
    .SCREEN_W  (W),
    .SCREEN_H  (H)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pixel_valid (pixel_valid),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .sprite_en   (sprite_en),
    .pix_hit     (pix_hit),
    .coll_mask   (coll_mask),
    .coll_valid  (coll_valid),
    .coll_ready  (coll_ready),
    .coll_overrun(coll_overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && coll_valid && coll_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_publish: got mask %b expected no result", coll_mask);
      end else begin
        check("coll_mask_accepted", {28'd0, coll_mask}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic set_sprite(input int i, input int x, input int y);
    sprite_x[7*i +: 7] = 7'(x);
    sprite_y[6*i +: 6] = 6'(y);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic scan_range(input int first, input int last, input bit fs_on_last);
    for (int i = first; i <= last; i++) begin
      pixel_x     = 7'(i % W);
      pixel_y     = 6'(i / W);
      pixel_valid = 1'b1;
      if (fs_on_last && i == last) frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
    end
    pixel_valid = 1'b0;
  endtask

  task automatic full_frame();
    pulse_fs();
    scan_range(0, LAST_IDX, 1'b0);
  endtask

  // Called right after the edge that sampled the last pixel: result must appear at edge 3.
  task automatic post_frame(input string tag, input logic exp_before, input bit ready_at_e2);
    check({tag, "_valid_e1"}, {31'd0, coll_valid}, {31'd0, exp_before});
    @(posedge clk); #1;
    check({tag, "_valid_e2"}, {31'd0, coll_valid}, {31'd0, exp_before});
    if (ready_at_e2) coll_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_e3"}, {31'd0, coll_valid}, 32'd1);
  endtask

  task automatic probe(input string name, input int x, input int y, input logic [N-1:0] exp);
    pixel_x     = 7'(x);
    pixel_y     = 6'(y);
    pixel_valid = 1'b1;
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    check(name, {28'd0, pix_hit}, {28'd0, exp});
    @(posedge clk); #1;
    check({name, "_hold"}, {28'd0, pix_hit}, {28'd0, exp});
  endtask

  initial begin
    rst_n       = 1'b1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_x     = '0;
    pixel_y     = '0;
    sprite_x    = '0;
    sprite_y    = '0;
    sprite_en   = '0;
    coll_ready  = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_pix_hit", {28'd0, pix_hit}, 32'd0);
    check("rst_coll_mask", {28'd0, coll_mask}, 32'd0);
    check("rst_coll_valid", {31'd0, coll_valid}, 32'd0);
    check("rst_overrun", {31'd0, coll_overrun}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Overlapping cars
    set_sprite(0, 10, 10); set_sprite(1, 15, 10); sprite_en = 4'b0011;
    exp_q.push_back(4'b0011);
    full_frame();
    post_frame("t1", 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;

    // Separated cars, then single-pixel probes against the latched shadows
    set_sprite(1, 40, 40);
    exp_q.push_back(4'b0000);
    full_frame();
    post_frame("t2", 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;
    probe("t2_wheel_11_10", 11, 10, 4'b0001);
    probe("t2_gap_10_10", 10, 10, 4'b0000);

    // Screen corners, result left pending
    set_sprite(0, 0, 0); set_sprite(1, 0, 0); set_sprite(2, 90, 60); sprite_en = 4'b0110;
    coll_ready = 1'b0;
    full_frame();
    post_frame("t3", 1'b0, 1'b0);
    check("t3_mask", {28'd0, coll_mask}, 32'd0);
    repeat (3) @(posedge clk); #1;
    probe("t3_corner_95_63", 95, 63, 4'b0100);
    probe("t3_wheel_1_0", 1, 0, 4'b0010);
    probe("t3_chassis_2_2", 2, 2, 4'b0010);
    probe("t3_origin_0_0", 0, 0, 4'b0000);
    probe("t3_left_89_60", 89, 60, 4'b0000);

    // Publish coinciding with acceptance of the pending result
    set_sprite(0, 10, 10); set_sprite(1, 15, 10); sprite_en = 4'b0011;
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0011);
    full_frame();
    post_frame("t4", 1'b1, 1'b1);
    check("t4_mask", {28'd0, coll_mask}, 32'h3);
    check("t4_no_overrun", {31'd0, coll_overrun}, 32'd0);
    repeat (3) @(posedge clk); #1;

    // Two frames with no acceptance
    coll_ready = 1'b0;
    full_frame();
    post_frame("t5a", 1'b0, 1'b0);
    check("t5a_overrun", {31'd0, coll_overrun}, 32'd0);
    set_sprite(2, 12, 12); sprite_en = 4'b0101;
    full_frame();
    post_frame("t5b", 1'b1, 1'b0);
    check("t5b_mask", {28'd0, coll_mask}, 32'h5);
    check("t5b_overrun", {31'd0, coll_overrun}, 32'd1);
    exp_q.push_back(4'b0101);
    coll_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_valid_cleared", {31'd0, coll_valid}, 32'd0);
    check("t5_overrun_sticky", {31'd0, coll_overrun}, 32'd1);
    repeat (2) @(posedge clk); #1;

    // Mid-frame position change, restart at (50,30)
    set_sprite(0, 10, 10); set_sprite(1, 60, 40); sprite_en = 4'b0011;
    pulse_fs();
    scan_range(0, 20 * W - 1, 1'b0);
    set_sprite(1, 15, 10);
    scan_range(20 * W, 30 * W + 50, 1'b1);
    exp_q.push_back(4'b0011);
    scan_range(0, LAST_IDX, 1'b0);
    post_frame("t6", 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;

    // Asynchronous reset in mid-scan
    pulse_fs();
    scan_range(0, 12 * W + 16, 1'b0);
    check("t7_prehit", {28'd0, pix_hit}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_pix_hit", {28'd0, pix_hit}, 32'd0);
    check("t7_rst_mask", {28'd0, coll_mask}, 32'd0);
    check("t7_rst_valid", {31'd0, coll_valid}, 32'd0);
    check("t7_rst_overrun", {31'd0, coll_overrun}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    scan_range(12 * W + 17, LAST_IDX, 1'b0);
    repeat (5) @(posedge clk); #1;
    check("t7_no_publish", {31'd0, coll_valid}, 32'd0);
    exp_q.push_back(4'b0011);
    full_frame();
    post_frame("t7", 1'b0, 1'b0);

    repeat (5) @(posedge clk); #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
